fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter (PC) and drives the memory's 8-bit address. Captures the combinationally-read 8-bit instruction code and assembles one- or two-byte instructions.
- Presents assembled instructions to the decoder over a valid/ready handshake.
- Accepts branch/jump redirects from execute.

Parameters:
- ADDR_W, 8, PC / memory address width.
- DATA_W, 8, instruction byte width.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset. Also held to the instruction memory, which loads its image while reset is high.
- fetch_en  input  1  1 = fetch may start a new instruction; 0 = hold in S_OP without PC advance.
- imem_addr  output  ADDR_W  address to instruction memory; always equals the PC register.
- imem_instr  input  DATA_W  instruction byte from memory; combinational, valid in the same cycle as imem_addr.
- br_taken  input  1  one-cycle redirect pulse from execute.
- br_target  input  ADDR_W  redirect PC; sampled when br_taken=1.
- instr_valid  output  1  assembled instruction available to decoder.
- instr_ready  input  1  decoder accepts the instruction this cycle.
- instr_op  output  DATA_W  opcode byte.
- instr_imm  output  DATA_W  immediate byte; 0 for one-byte instructions.
- instr_pc  output  ADDR_W  address of the opcode byte.
- instr_two  output  1  1 = instruction carried an immediate byte.

Behaviour:
- Reset (reset=1 at clock edge):
  - PC <= RESET_PC; state <= S_OP.
  - instr_valid, instr_op, instr_imm, instr_pc and instr_two all <= 0.
  - imem_addr = RESET_PC.
  - No fetch occurs while reset is high. The first fetch is in the first cycle after reset deasserts.
- Instruction format: opcode bit 7 = 1 marks a two-byte instruction (opcode + immediate); bit 7 = 0 marks a one-byte instruction.
- State machine S_OP, S_IMM, S_ISSUE:
  - S_OP, fetch_en=0: hold; PC unchanged; instr_valid=0.
  - S_OP, fetch_en=1: op_reg <= imem_instr; pc_reg <= PC; PC <= PC+1.
    - If imem_instr[7]=1 -> S_IMM.
    - Else imm_reg <= 0, two <= 0 -> S_ISSUE.
  - S_IMM: imm_reg <= imem_instr; two <= 1; PC <= PC+1 -> S_ISSUE. fetch_en is ignored once an instruction is started.
  - S_ISSUE: instr_valid=1 and all instr_* outputs held stable. On instr_valid & instr_ready -> S_OP. instr_valid drops the next cycle unless a new instruction completes.
- Outputs are registered; instr_valid = (state==S_ISSUE).
- Latency from entering S_OP with fetch_en=1 to instr_valid=1: 1 cycle for one-byte, 2 cycles for two-byte.
- Peak throughput: one one-byte instruction per 2 cycles.
- PC arithmetic is modulo 2^ADDR_W: 8'hFF+1 = 8'h00. A two-byte instruction at 8'hFF takes its immediate from 8'h00.
- Redirect (br_taken=1) in any state: PC <= br_target; state <= S_OP.
  - Any partially assembled or unaccepted instruction is discarded.
  - instr_valid=0 the next cycle.
- Simultaneous events:
  - Priority is reset > redirect > handshake/advance.
  - Redirect coincident with a handshake: the instruction counts as consumed and the PC takes br_target.
  - Redirect while in S_IMM: the immediate is not captured.
- Decoder stalls (instr_ready=0) hold S_ISSUE indefinitely with no PC change.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding (S_OP=2'd0, S_IMM=2'd1, S_ISSUE=2'd2);
  - TWO_BYTE_BIT=7;
  - default RESET_PC.
- One natural sub-module, fetch_pc: the PC register with synchronous reset, load (br_target) and increment enable. The FSM and instruction registers stay in fetch_unit.

Test Plan:
- Reset, then memory [0]=8'h12, [1]=8'h05, fetch_en=1, instr_ready=1 -> instr_valid in cycle 2 with op=12, imm=00, pc=00, two=0. Next instruction has op=05, pc=01.
- Memory [0]=8'hA3, [1]=8'h7F -> after 2 cycles instr_valid=1 with op=A3, imm=7F, pc=00, two=1; PC=02.
- Hold instr_ready=0 for 5 cycles in S_ISSUE -> outputs stable, imem_addr unchanged. Release -> one handshake, then next fetch.
- Pulse br_taken with br_target=8'h40 while in S_IMM -> next cycle imem_addr=40 and instr_valid=0. Next instruction reports pc=40.
- Two-byte opcode at 8'hFF (imm at 8'h00) -> imm taken from address 00; PC wraps to 01.
- Assert reset while instr_valid=1 -> next cycle instr_valid=0, imem_addr=RESET_PC, and all instr_* outputs are 0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_pkg                                              |
// | Description : Shared state encoding and constants for the fetch unit |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fetch_pkg;

    typedef enum logic [1:0] {
        S_OP    = 2'd0,
        S_IMM   = 2'd1,
        S_ISSUE = 2'd2
    } state_e;

    localparam int         TWO_BYTE_BIT     = 7;
    localparam logic [7:0] DEFAULT_RESET_PC = 8'h00;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_if                                               |
// | Description : Memory, redirect and decoder signals of the fetch unit |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              fetch_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_instr;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_op;
    logic [DATA_W-1:0] instr_imm;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_two;

    modport master (
        input  fetch_en, imem_instr, br_taken, br_target, instr_ready,
        output imem_addr, instr_valid, instr_op, instr_imm, instr_pc, instr_two
    );

    modport slave (
        output fetch_en, imem_instr, br_taken, br_target, instr_ready,
        input  imem_addr, instr_valid, instr_op, instr_imm, instr_pc, instr_two
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_pc                                               |
// | Description : Program counter with reset, redirect load and increment|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              load_i,
    input  wire logic [ADDR_W-1:0] target_i,
    input  wire logic              inc_i,
    output logic      [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Redirect wins over increment; the add wraps naturally at 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_unit                                             |
// | Description : Fetches and assembles 1/2-byte instructions for decode |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  wire logic clk,
    input  wire logic reset,
    fetch_if.master   bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0] opc_q, opc_d;
    logic              two_q, two_d;
    logic              pc_inc;
    logic              pc_load;
    logic [ADDR_W-1:0] pc;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load_i   (pc_load),
        .target_i (bus.br_target),
        .inc_i    (pc_inc),
        .pc_o     (pc)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        imm_d   = imm_q;
        opc_d   = opc_q;
        two_d   = two_q;
        pc_inc  = 1'b0;
        pc_load = 1'b0;

        // A redirect abandons whatever is in flight, including an unaccepted issue.
        if (bus.br_taken) begin
            pc_load = 1'b1;
            state_d = S_OP;
        end else begin
            case (state_q)
                S_OP: begin
                    if (bus.fetch_en) begin
                        op_d   = bus.imem_instr;
                        opc_d  = pc;
                        pc_inc = 1'b1;
                        if (bus.imem_instr[TWO_BYTE_BIT]) begin
                            state_d = S_IMM;
                        end else begin
                            imm_d   = '0;
                            two_d   = 1'b0;
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_IMM: begin
                    imm_d   = bus.imem_instr;
                    two_d   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    if (bus.instr_ready) begin
                        state_d = S_OP;
                    end
                end
                default: begin
                    state_d = S_OP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_OP;
            op_q    <= '0;
            imm_q   <= '0;
            opc_q   <= '0;
            two_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            opc_q   <= opc_d;
            two_q   <= two_d;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (state_q == S_ISSUE);
    assign bus.instr_op    = op_q;
    assign bus.instr_imm   = imm_q;
    assign bus.instr_pc    = opc_q;
    assign bus.instr_two   = two_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                          |
// | Description : Directed and random self-checking bench for fetch_unit |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

    logic clk;
    logic reset;
    logic [7:0] mem [256];

    int n_chk;
    int n_fail;

    fetch_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_instr = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_instr(input string tag, input logic [7:0] op, input logic [7:0] imm,
                             input logic [7:0] pc, input logic two, input logic [7:0] addr);
        chk({tag, ".valid"}, {15'd0, bus.instr_valid}, 16'd1);
        chk({tag, ".op"},    {8'd0, bus.instr_op},     {8'd0, op});
        chk({tag, ".imm"},   {8'd0, bus.instr_imm},    {8'd0, imm});
        chk({tag, ".pc"},    {8'd0, bus.instr_pc},     {8'd0, pc});
        chk({tag, ".two"},   {15'd0, bus.instr_two},   {15'd0, two});
        chk({tag, ".addr"},  {8'd0, bus.imem_addr},    {8'd0, addr});
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] addr);
        chk({tag, ".valid"}, {15'd0, bus.instr_valid}, 16'd0);
        chk({tag, ".addr"},  {8'd0, bus.imem_addr},    {8'd0, addr});
    endtask

    initial begin
        logic [7:0] exp_pc;
        logic [7:0] op;
        logic [7:0] len;
        logic       v, rdy, br, prev_br;
        logic [7:0] tgt, prev_tgt;

        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h12; mem[8'h01] = 8'h05; mem[8'h02] = 8'hA3; mem[8'h03] = 8'h7F;
        mem[8'h04] = 8'h81; mem[8'h05] = 8'h11; mem[8'h40] = 8'h22; mem[8'hFF] = 8'h9C;

        reset = 1'b1; bus.fetch_en = 1'b0; bus.instr_ready = 1'b0;
        bus.br_taken = 1'b0; bus.br_target = 8'h00;
        cyc(); cyc();
        chk_idle("reset", 8'h00);
        chk("reset.op",  {8'd0, bus.instr_op},  16'd0);
        chk("reset.imm", {8'd0, bus.instr_imm}, 16'd0);
        chk("reset.pc",  {8'd0, bus.instr_pc},  16'd0);
        chk("reset.two", {15'd0, bus.instr_two}, 16'd0);

        // One-byte instructions back to back
        reset = 1'b0; bus.fetch_en = 1'b1; bus.instr_ready = 1'b1;
        cyc(); chk_instr("one0", 8'h12, 8'h00, 8'h00, 1'b0, 8'h01);
        cyc(); chk_idle("one0_done", 8'h01);
        cyc(); chk_instr("one1", 8'h05, 8'h00, 8'h01, 1'b0, 8'h02);
        cyc(); chk_idle("one1_done", 8'h02);

        // Two-byte instruction then a 5-cycle decoder stall
        cyc(); chk_idle("two_imm", 8'h03);
        bus.instr_ready = 1'b0;
        cyc(); chk_instr("two", 8'hA3, 8'h7F, 8'h02, 1'b1, 8'h04);
        for (int i = 0; i < 5; i++) begin
            cyc(); chk_instr("stall", 8'hA3, 8'h7F, 8'h02, 1'b1, 8'h04);
        end
        bus.instr_ready = 1'b1;
        cyc(); chk_idle("stall_release", 8'h04);

        // Redirect while assembling a two-byte instruction
        cyc(); chk_idle("pre_br_imm", 8'h05);
        bus.br_taken = 1'b1; bus.br_target = 8'h40;
        cyc(); chk_idle("br_in_imm", 8'h40);
        bus.br_taken = 1'b0;
        cyc(); chk_instr("after_br", 8'h22, 8'h00, 8'h40, 1'b0, 8'h41);

        // Redirect coincident with a handshake, to a two-byte op at FF
        bus.br_taken = 1'b1; bus.br_target = 8'hFF;
        cyc(); chk_idle("br_hs", 8'hFF);
        bus.br_taken = 1'b0;
        cyc(); chk_idle("wrap_imm", 8'h00);
        cyc(); chk_instr("wrap", 8'h9C, 8'h12, 8'hFF, 1'b1, 8'h01);

        // Reset while an instruction is being offered
        reset = 1'b1;
        cyc();
        chk_idle("rst_valid", 8'h00);
        chk("rst_valid.op",  {8'd0, bus.instr_op},  16'd0);
        chk("rst_valid.imm", {8'd0, bus.instr_imm}, 16'd0);
        chk("rst_valid.pc",  {8'd0, bus.instr_pc},  16'd0);
        chk("rst_valid.two", {15'd0, bus.instr_two}, 16'd0);

        // fetch_en low holds in place
        reset = 1'b0; bus.fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk_idle("hold", 8'h00);
        end

        // Random phase: transaction-level model tracks where the next instruction starts
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        reset = 1'b1; cyc(); reset = 1'b0;
        exp_pc = 8'h00; prev_br = 1'b0; prev_tgt = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            op  = mem[exp_pc];
            len = op[7] ? 8'd2 : 8'd1;
            if (bus.instr_valid === 1'b1)
                chk_instr("rand", op, op[7] ? mem[8'(exp_pc + 8'd1)] : 8'h00, exp_pc, op[7],
                          8'(exp_pc + len));
            if (prev_br)
                chk_idle("rand_br", prev_tgt);
            v   = bus.instr_valid;
            rdy = ($urandom % 3) != 0;
            br  = ($urandom % 12) == 0;
            tgt = 8'($urandom);
            bus.fetch_en    = ($urandom % 4) != 0;
            bus.instr_ready = rdy;
            bus.br_taken    = br;
            bus.br_target   = tgt;
            cyc();
            if (br)            exp_pc = tgt;
            else if (v && rdy) exp_pc = 8'(exp_pc + len);
            prev_br  = br;
            prev_tgt = tgt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
